// File: rtl/clk_en_pll_gen.sv
// clk_en_pll_gen: lock-gated per-channel clock-enable/duty generator on refclk; cfg_* handshake sets div/phase, ce_out/clk_out/locked are registered outputs
module clk_en_pll_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 16,
  parameter int DEF_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W = 5
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] ONE = 1;
  localparam logic [DIV_W:0] HONE = 1;
  typedef enum logic {SETTLE, RUN} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] lcnt;
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] cnt [NUM_CH];
  logic [DIV_W-1:0] cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] ce_nxt, clk_nxt;
  logic acc, bad, take, lock_done;
  assign cfg_ready = state == RUN;
  assign locked = state == RUN;
  assign acc = cfg_valid && cfg_ready;
  assign bad = cfg_div == '0 || cfg_phase >= cfg_div || int'(cfg_ch) >= NUM_CH;
  assign take = acc && !bad;
  assign lock_done = lcnt == LW'(LOCK_CYCLES - 1);
  always_ff @(posedge refclk)
    state <= rst ? SETTLE : state_nxt;
  always_comb
    state_nxt = state == SETTLE ? (lock_done ? RUN : SETTLE) : (take ? SETTLE : RUN);
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = state_nxt == SETTLE ? '0 :
                   state == SETTLE ? phase_q[i] :
                   cnt[i] == div_q[i] - ONE ? '0 : cnt[i] + ONE;
      ce_nxt[i] = state_nxt == RUN && cnt_nxt[i] == div_q[i] - ONE;
      clk_nxt[i] = state_nxt == RUN && {1'b0, cnt_nxt[i]} < (({1'b0, div_q[i]} + HONE) >> 1);
    end
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      lcnt <= '0;
      cfg_err <= 1'b0;
      ce_out <= '0;
      clk_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      lcnt <= state == SETTLE && state_nxt == SETTLE ? lcnt + LW'(1) : '0;
      cfg_err <= acc && bad;
      ce_out <= ce_nxt;
      clk_out <= clk_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (take && cfg_ch == CH_W'(i)) begin
          div_q[i] <= cfg_div;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_en_pll_gen.sv
// tb_clk_en_pll_gen: directed self-checking bench for clk_en_pll_gen with default parameters
module tb_clk_en_pll_gen;
  logic refclk, rst, cfg_valid, cfg_ready, cfg_err, locked;
  logic [4:0] cfg_ch;
  logic [15:0] cfg_div, cfg_phase;
  logic [1:0] ce_out, clk_out;
  int n_cmp = 0, n_bad = 0, k = 0;
  clk_en_pll_gen dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .ce_out(ce_out), .clk_out(clk_out), .locked(locked)
  );
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic step;
    @(posedge refclk);
    #1;
  endtask
  task automatic settle_check;
    for (int s = 0; s < 16; s++) begin
      chk("settle_locked", 32'(locked), 0);
      chk("settle_ready", 32'(cfg_ready), 0);
      chk("settle_ce", 32'(ce_out), 0);
      chk("settle_clk", 32'(clk_out), 0);
      chk("settle_err", 32'(cfg_err), 0);
      step;
    end
    k = 0;
  endtask
  task automatic run_check(input int n, input int d0, input int p0, input int d1, input int p1);
    for (int j = 0; j < n; j++) begin
      int c0, c1;
      logic [1:0] ece, eclk;
      c0 = (p0 + k) % d0;
      c1 = (p1 + k) % d1;
      ece = {c1 == d1 - 1, c0 == d0 - 1};
      eclk = {c1 < (d1 + 1) / 2, c0 < (d0 + 1) / 2};
      chk("run_locked", 32'(locked), 1);
      chk("run_ready", 32'(cfg_ready), 1);
      chk("run_ce", 32'(ce_out), 32'(ece));
      chk("run_clk", 32'(clk_out), 32'(eclk));
      chk("run_err", 32'(cfg_err), 0);
      step;
      k++;
    end
  endtask
  task automatic drive_cfg(input int ch, input int dv, input int ph);
    chk("cfg_ready_before", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch = 5'(ch);
    cfg_div = 16'(dv);
    cfg_phase = 16'(ph);
    step;
    cfg_valid = 1'b0;
  endtask
  task automatic bad_cfg(input string tag, input int ch, input int dv, input int ph);
    drive_cfg(ch, dv, ph);
    chk({tag, "_err"}, 32'(cfg_err), 1);
    chk({tag, "_locked"}, 32'(locked), 1);
    step;
    chk({tag, "_err_clr"}, 32'(cfg_err), 0);
    k += 2;
  endtask
  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    cfg_phase = '0;
    repeat (3) step;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_ce", 32'(ce_out), 0);
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;
    settle_check;
    run_check(6, 2, 0, 2, 0);
    drive_cfg(0, 5, 2);
    settle_check;
    run_check(10, 5, 2, 2, 0);
    bad_cfg("div0", 0, 0, 0);
    run_check(3, 5, 2, 2, 0);
    bad_cfg("ph_ge_div", 0, 4, 4);
    run_check(3, 5, 2, 2, 0);
    bad_cfg("ch_oob", 3, 4, 1);
    run_check(5, 5, 2, 2, 0);
    drive_cfg(1, 4, 1);
    cfg_valid = 1'b1;
    cfg_ch = 5'd1;
    cfg_div = 16'd3;
    cfg_phase = 16'd2;
    settle_check;
    chk("held_locked", 32'(locked), 1);
    chk("held_ready", 32'(cfg_ready), 1);
    step;
    cfg_valid = 1'b0;
    settle_check;
    run_check(8, 5, 2, 3, 2);
    drive_cfg(0, 7, 3);
    repeat (5) step;
    chk("mid_settle_locked", 32'(locked), 0);
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    settle_check;
    run_check(6, 2, 0, 2, 0);
    drive_cfg(1, 1, 0);
    settle_check;
    run_check(6, 2, 0, 1, 0);
    chk("n1_ce_at_accept", 32'(ce_out[1]), 1);
    drive_cfg(0, 2, 0);
    settle_check;
    run_check(4, 2, 0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
